tentativa_ctrl: RTL
===================

# tentativa_ctrl

Game-flow controller for the 6-bit code-guessing datapath. Conditions the raw ENTER push-button (KEY[3]), captures the guess on SW[5:0], and drives the guess-display path with a latched value plus a load strobe. Scores each guess against the secret code and counts attempts up to a limit. Sits between board I/O and the HEX display and status LEDs.

## Interface
- MAX_TENT, 8: attempts allowed per game; legal range 1..15.
- DEBOUNCE_CYC, 4: cycles the synchronized button must hold a new level before it is accepted. Used only with the debounce macro; ≥2. Board build overrides with ~1_000_000.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- key_enter_n  in  1  raw ENTER button, active-low (0 = pressed), asynchronous to clk.
- sw_tentativa  in  6  guess switches SW[5:0].
- segredo  in  6  secret code; held stable by its owner during a game.
- tentativa_atual  out  6  last captured guess; feeds the display.
- load_disp  out  1  one-cycle pulse in the cycle tentativa_atual takes a new value.
- acertos  out  3  bit positions of the last guess equal to segredo, 0..6.
- num_tent  out  4  guesses consumed this game.
- venceu  out  1  level; game won.
- perdeu  out  1  level; game lost.

## Operation
- Input conditioning: two-flop synchronizer (s1, s2) on key_enter_n, both reset to 1. Debounced level `estavel`, reset 1. Press event `ev` = one-cycle pulse when `estavel` goes 1→0. Releases produce no event. Holding the button produces exactly one event.
- States: ESPERA (reset state), COMPARA, VITORIA, DERROTA.
- ESPERA + ev:
  - tentativa_atual ← sw_tentativa
  - num_tent ← num_tent+1
  - load_disp = 1 for that cycle
  - → COMPARA
- COMPARA (always exactly one cycle):
  - acertos ← popcount(~(tentativa_atual ^ segredo)), 3-bit, max 6.
  - If tentativa_atual == segredo: venceu ← 1, → VITORIA.
  - Else if num_tent == MAX_TENT: perdeu ← 1, → DERROTA.
  - Else → ESPERA.
  - Win takes priority over loss when both hold on the last attempt.
- VITORIA / DERROTA + ev (restart):
  - num_tent, acertos, venceu, perdeu ← 0; → ESPERA.
  - tentativa_atual is unchanged and no load_disp pulse is produced. The restart press is not a guess.
- ev arriving while in COMPARA is dropped.
- num_tent never exceeds MAX_TENT and never wraps.
- Reset, asserted at any time including mid-COMPARA: state ESPERA. tentativa_atual, acertos, num_tent = 0. load_disp, venceu, perdeu = 0. s1, s2, estavel = 1. Debounce counter = 0.

## Timing
- key_enter_n falls before edge N: s2 = 0 after edge N+1.
- With debounce: estavel = 0 after edge N+1+DEBOUNCE_CYC; ev high in the following cycle; capture at edge N+2+DEBOUNCE_CYC. Without debounce: ev high in cycle after edge N+1; capture at edge N+2.
- Capture edge: tentativa_atual, num_tent, and load_disp all update together.
- acertos, venceu, and perdeu are valid one edge after the capture edge.
- Debounce counter resets whenever s2 equals estavel. Glitches shorter than DEBOUNCE_CYC cycles are ignored.
- Minimum spacing between accepted presses is 2·DEBOUNCE_CYC cycles, so COMPARA never overlaps a new ev when debounce is enabled.

## Configuration
- TENTATIVA_DEBOUNCE_EN defined: DEBOUNCE_CYC filter is compiled in as described.
- Undefined: estavel = s2 directly; every synchronized falling edge is an event, including bounces; DEBOUNCE_CYC is ignored.

## Test plan
All scenarios use debounce enabled, DEBOUNCE_CYC=4, MAX_TENT=3.
- Reset check: assert reset mid-run → all outputs 0 immediately. Release, press with sw=6'h15 → load_disp one pulse, tentativa_atual=6'h15, num_tent=1, capture exactly 6 cycles after the falling input edge.
- Wrong guess: segredo=6'h2A, guess 6'h28 → acertos=5, venceu=0, state back in ESPERA.
- Win: segredo=6'h2A, guess 6'h2A on attempt 2 → venceu=1, acertos=6, num_tent=2. Next press clears all to 0 with no load_disp; tentativa_atual stays 6'h2A.
- Loss: three wrong guesses → perdeu=1 after the third, num_tent=3. A correct guess on attempt 3 instead gives venceu=1, perdeu=0.
- Bounce: key_enter_n toggled low/high in 2-cycle bursts for 12 cycles, then held low 20 cycles → exactly one capture, num_tent increments by 1. Repeat with the macro undefined → multiple captures observed.

Source files
------------

// File: rtl/tentativa_ctrl.sv
// tentativa_ctrl: ENTER conditioning, guess capture, scoring, attempt count.
// Define TENTATIVA_DEBOUNCE_EN to compile in the DEBOUNCE_CYC filter.
module tentativa_ctrl #(
  parameter int MAX_TENT     = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_enter_n,
  input  logic [5:0] sw_tentativa,
  input  logic [5:0] segredo,
  output logic [5:0] tentativa_atual,
  output logic       load_disp,
  output logic [2:0] acertos,
  output logic [3:0] num_tent,
  output logic       venceu,
  output logic       perdeu
);

  if (MAX_TENT < 1 || MAX_TENT > 15) begin : g_bad_max
    $error("MAX_TENT must be 1..15");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_deb
    $error("DEBOUNCE_CYC must be >= 2");
  end

  localparam logic [3:0] MAX_N = 4'(MAX_TENT);

  typedef enum logic [1:0] {
    ESPERA,
    COMPARA,
    VITORIA,
    DERROTA
  } estado_t;

  estado_t estado;
  logic    s1, s2;
  logic    estavel, estavel_q;
  logic    ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_enter_n;
      s2 <= s1;
    end
  end

`ifdef TENTATIVA_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] cnt;

  // A new level is taken only after it has held for DEBOUNCE_CYC edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      estavel <= 1'b1;
    end else if (s2 == estavel) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      estavel <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign estavel = s2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estavel_q <= 1'b1;
    else       estavel_q <= estavel;
  end

  assign ev = estavel_q & ~estavel;

  function automatic logic [2:0] iguais(
    input logic [5:0] a,
    input logic [5:0] b
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, ~(a[i] ^ b[i])};
    end
    return n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado          <= ESPERA;
      tentativa_atual <= '0;
      load_disp       <= 1'b0;
      acertos         <= '0;
      num_tent        <= '0;
      venceu          <= 1'b0;
      perdeu          <= 1'b0;
    end else begin
      load_disp <= 1'b0;
      unique case (estado)
        ESPERA: begin
          if (ev) begin
            tentativa_atual <= sw_tentativa;
            num_tent        <= num_tent + 4'd1;
            load_disp       <= 1'b1;
            estado          <= COMPARA;
          end
        end
        COMPARA: begin
          acertos <= iguais(tentativa_atual, segredo);
          if (tentativa_atual == segredo) begin
            venceu <= 1'b1;
            estado <= VITORIA;
          end else if (num_tent == MAX_N) begin
            perdeu <= 1'b1;
            estado <= DERROTA;
          end else begin
            estado <= ESPERA;
          end
        end
        VITORIA, DERROTA: begin
          // Restart press: clears the score but keeps the displayed guess.
          if (ev) begin
            num_tent <= '0;
            acertos  <= '0;
            venceu   <= 1'b0;
            perdeu   <= 1'b0;
            estado   <= ESPERA;
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

endmodule
